// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : oversampling UART receiver with a valid/ready output and error flags
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_rx #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_BITS + 1);

   localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BITS_LAST = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   state_t               state;
   state_t               next_state;
   logic                 sync_1;
   logic                 rx_sync;
   logic [BAUD_W-1:0]    baud_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic [DATA_BITS-1:0] shift_next;
   logic                 shift_en;
   logic                 load;
   logic                 ovr_set;
   logic                 ferr_set;

   // Two-flop synchronizer; resets high so the idle line never looks like a start bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_1  <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         sync_1  <= rx_in;
         rx_sync <= sync_1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      shift_en   = 1'b0;
      load       = 1'b0;
      ovr_set    = 1'b0;
      ferr_set   = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_sync) next_state = START;
         end
         START: begin
            if (baud_cnt == HALF_LAST) next_state = rx_sync ? IDLE : DATA;
         end
         DATA: begin
            if (baud_cnt == BAUD_LAST) begin
               shift_en = 1'b1;
               if (bit_cnt == BITS_LAST) next_state = STOP;
            end
         end
         STOP: begin
            if (baud_cnt == BAUD_LAST) begin
               if (rx_sync) begin
                  next_state = IDLE;
                  if (!data_valid || data_ready) load = 1'b1;
                  else                           ovr_set = 1'b1;
               end else begin
                  next_state = WAIT_HIGH;
                  ferr_set   = 1'b1;
               end
            end
         end
         WAIT_HIGH: begin
            if (rx_sync) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // New bit enters the MSB so the first (LSB) bit lands in bit 0 after the last shift
   always_comb begin
      shift_next                = shreg >> 1;
      shift_next[DATA_BITS-1]   = rx_sync;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
      end else begin
         if (next_state != state) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
         end else if (shift_en) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + BIT_W'(1);
         end else if (state == START || state == DATA || state == STOP) begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
         end
         if (shift_en) shreg <= shift_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out    <= '0;
         data_valid  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         frame_err   <= ferr_set;
         overrun_err <= ovr_set;
         if (load) begin
            data_out   <= shreg;
            data_valid <= 1'b1;
         end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// tb_uart_rx : directed frame vectors and corner-case sequences for uart_rx
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_in = 1'b1;
   logic       data_ready = 1'b1;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       overrun_err;
   logic       busy;

   uart_rx #(.DATA_BITS(8), .CLKS_PER_BIT(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_in       (rx_in),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .frame_err   (frame_err),
      .overrun_err (overrun_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Cumulative event counters; the test compares differences across a sequence
   int         dv_rises = 0, dv_hi = 0, fe_hi = 0, ov_hi = 0, both_hi = 0;
   int         rise_cyc = 0, fe_cyc = 0, ov_cyc = 0;
   logic [7:0] rise_data = '0;
   logic       dv_q = 1'b0;

   always @(negedge clk) begin
      if (data_valid && !dv_q) begin
         dv_rises  <= dv_rises + 1;
         rise_cyc  <= cyc;
         rise_data <= data_out;
      end
      if (data_valid) dv_hi <= dv_hi + 1;
      if (frame_err) begin
         fe_hi  <= fe_hi + 1;
         fe_cyc <= cyc;
      end
      if (overrun_err) begin
         ov_hi  <= ov_hi + 1;
         ov_cyc <= cyc;
      end
      if (frame_err && overrun_err) both_hi <= both_hi + 1;
      dv_q <= data_valid;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Caller is 1 time unit after an edge; c is that edge's count, so Es = c + 79
   task automatic send_frame(input logic [7:0] b, input logic stop, output int c);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      c    = cyc;
      for (int k = 0; k < 10; k++) begin
         rx_in = bits[k];
         repeat (8) step();
      end
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_rises;
      int         exp_fe;
   } vec_t;

   vec_t vecs[7];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, c0, c1, c2, s_r, s_h, s_f, s_o;

      vecs[0] = '{8'hA5, 1'b1, 1, 0};
      vecs[1] = '{8'h00, 1'b1, 1, 0};
      vecs[2] = '{8'hFF, 1'b1, 1, 0};
      vecs[3] = '{8'h5A, 1'b1, 1, 0};
      vecs[4] = '{8'h01, 1'b1, 1, 0};
      vecs[5] = '{8'h80, 1'b1, 1, 0};
      vecs[6] = '{8'hC3, 1'b0, 0, 1};

      repeat (3) step();
      chk("rst_data_out", data_out, 0);
      chk("rst_data_valid", data_valid, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_overrun_err", overrun_err, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b0;
      repeat (4) step();

      for (int i = 0; i < 7; i++) begin
         s_r = dv_rises; s_h = dv_hi; s_f = fe_hi; s_o = ov_hi;
         send_frame(vecs[i].data, vecs[i].stop, c);
         rx_in = 1'b1;
         repeat (10) step();
         chk($sformatf("vec%0d_rises", i), dv_rises - s_r, vecs[i].exp_rises);
         chk($sformatf("vec%0d_valid_width", i), dv_hi - s_h, vecs[i].exp_rises);
         chk($sformatf("vec%0d_frame_err", i), fe_hi - s_f, vecs[i].exp_fe);
         chk($sformatf("vec%0d_overrun", i), ov_hi - s_o, 0);
         chk($sformatf("vec%0d_busy", i), busy, 0);
         if (vecs[i].exp_rises == 1) begin
            chk($sformatf("vec%0d_data", i), rise_data, vecs[i].data);
            chk($sformatf("vec%0d_latency", i), rise_cyc - c, 79);
         end
      end

      // Start-bit glitch: 3 cycles low
      s_r = dv_rises; s_f = fe_hi; s_o = ov_hi;
      rx_in = 1'b0;
      repeat (3) step();
      rx_in = 1'b1;
      repeat (2) step();
      chk("glitch_busy_high", busy, 1);
      repeat (10) step();
      chk("glitch_busy_low", busy, 0);
      chk("glitch_rises", dv_rises - s_r, 0);
      chk("glitch_errs", (fe_hi - s_f) + (ov_hi - s_o), 0);

      // Framing error followed by a 40-cycle break
      s_r = dv_rises; s_f = fe_hi;
      send_frame(8'h3C, 1'b0, c);
      rx_in = 1'b0;
      repeat (40) step();
      chk("break_fe_count", fe_hi - s_f, 1);
      chk("break_fe_time", fe_cyc - c, 79);
      chk("break_busy_wait", busy, 1);
      chk("break_valid", data_valid, 0);
      chk("break_rises", dv_rises - s_r, 0);
      rx_in = 1'b1;
      repeat (6) step();
      chk("break_busy_release", busy, 0);

      // Overrun: consumer stalled across two frames
      data_ready = 1'b0;
      s_r = dv_rises; s_f = fe_hi; s_o = ov_hi;
      send_frame(8'h11, 1'b1, c1);
      send_frame(8'h22, 1'b1, c2);
      repeat (5) step();
      chk("ovr_data", data_out, 8'h11);
      chk("ovr_valid", data_valid, 1);
      chk("ovr_rises", dv_rises - s_r, 1);
      chk("ovr_count", ov_hi - s_o, 1);
      chk("ovr_time", ov_cyc - c2, 79);
      chk("ovr_fe", fe_hi - s_f, 0);
      data_ready = 1'b1;
      step();
      chk("ovr_drain_valid", data_valid, 0);
      chk("ovr_drain_data", data_out, 8'h11);

      // Ready pulsed exactly on the edge the second byte loads
      data_ready = 1'b0;
      s_r = dv_rises; s_o = ov_hi;
      send_frame(8'h55, 1'b1, c1);
      fork
         send_frame(8'hAA, 1'b1, c2);
         begin
            while (cyc != c1 + 158) step();
            data_ready = 1'b1;
            step();
            data_ready = 1'b0;
         end
      join
      repeat (3) step();
      chk("b2b_data", data_out, 8'hAA);
      chk("b2b_valid", data_valid, 1);
      chk("b2b_overrun", ov_hi - s_o, 0);
      chk("b2b_rises", dv_rises - s_r, 1);
      data_ready = 1'b1;
      step();
      chk("b2b_drain", data_valid, 0);

      // Reset during data bit 4 of 0xFF
      c0 = cyc;
      fork
         send_frame(8'hFF, 1'b1, c);
         begin
            while (cyc != c0 + 44) step();
            reset = 1'b1;
            #1;
            chk("midrst_data_out", data_out, 0);
            chk("midrst_valid", data_valid, 0);
            chk("midrst_busy", busy, 0);
            chk("midrst_errs", frame_err + overrun_err, 0);
            step();
            reset = 1'b0;
         end
      join
      repeat (4) step();
      s_r = dv_rises; s_f = fe_hi; s_o = ov_hi;
      send_frame(8'h81, 1'b1, c);
      repeat (10) step();
      chk("postrst_rises", dv_rises - s_r, 1);
      chk("postrst_data", rise_data, 8'h81);
      chk("postrst_latency", rise_cyc - c, 79);
      chk("postrst_errs", (fe_hi - s_f) + (ov_hi - s_o), 0);

      chk("err_exclusive", both_hi, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive datapath and control. It is the receiving end of the team's 10-bit UART frame: start bit 0, DATA_BITS data bits LSB first, stop bit 1, idle line high.
- Oversamples the asynchronous serial input with a clock-cycle baud counter and samples each bit at its midpoint.
- Assembles the byte and presents it on a valid/ready handshake to the consuming logic, with framing and overrun error flags.

Parameters:
- DATA_BITS, 8, data bits per frame (1..8).
- CLKS_PER_BIT, 8, clk cycles per serial bit. Even, >=4. Must match the transmitter's bit period.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_in  in  1  serial line, asynchronous to clk, idle high.
- data_out  out  DATA_BITS  received byte. Stable while data_valid=1.
- data_valid  out  1  data_out holds an unconsumed byte.
- data_ready  in  1  consumer accepts data_out on a clk edge where data_valid=1.
- frame_err  out  1  1-cycle pulse: stop bit sampled 0.
- overrun_err  out  1  1-cycle pulse: completed frame dropped because the previous byte was unconsumed.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, active-high):
  - Both synchronizer flops, and therefore rx_sync, go to 1. State goes to IDLE. Baud and bit counters go to 0.
  - Outputs: data_out=0, data_valid=0, frame_err=0, overrun_err=0, busy=0.
  - Reset mid-frame abandons the frame with no error pulse.
- Synchronizer: rx_in passes through 2 flops to give rx_sync. The FSM uses only rx_sync.
- Counters: baud_cnt is $clog2(CLKS_PER_BIT) bits wide. bit_cnt is $clog2(DATA_BITS+1) bits wide. Both clear on every state change.
- States:
  - IDLE:
    - If rx_sync=0, go to START.
    - Edge E0 is the clk edge of that transition. If rx_in falls before edge k, then E0=k+2.
  - START:
    - baud_cnt increments each cycle.
    - At baud_cnt==CLKS_PER_BIT/2-1 (edge E0+CLKS_PER_BIT/2), sample rx_sync.
    - If 0, go to DATA. If 1, treat it as a glitch and return to IDLE silently.
  - DATA:
    - At baud_cnt==CLKS_PER_BIT-1, sample rx_sync into the shift register, shifting right with the new bit entering the MSB. Then increment bit_cnt and clear baud_cnt.
    - After the DATA_BITS-th sample, go to STOP.
    - The sample for data bit i falls at E0+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT.
  - STOP: at baud_cnt==CLKS_PER_BIT-1 (edge Es = E0+CLKS_PER_BIT/2+(DATA_BITS+1)*CLKS_PER_BIT), sample rx_sync.
    - Sample 1, and (data_valid=0 or data_ready=1): load data_out and set data_valid at Es. Go to IDLE.
    - Sample 1, and data_valid=1 and data_ready=0: keep the old data_out, pulse overrun_err for the cycle after Es, discard the new byte. Go to IDLE.
    - Sample 0: pulse frame_err, discard the byte, go to WAIT_HIGH. data_valid and data_out are unchanged.
  - WAIT_HIGH: stay until rx_sync=1, then go to IDLE. A held-low (break) line does not retrigger a frame.
- Handshake:
  - data_valid clears on any edge with data_valid=1 and data_ready=1, unless a new byte loads on the same edge; in that case data_valid stays 1 with the new data.
  - data_ready is ignored while data_valid=0.
- Latency: data_valid rises at Es. With defaults that is E0+76.
- Error pulses are exactly 1 cycle. They are never asserted together.
- Back-to-back frames: IDLE is re-entered at Es, so a start bit immediately following the stop bit is detected with no lost frame. A stop bit shortened by up to CLKS_PER_BIT/2 cycles is tolerated.

Test Plan (defaults, consumer holds data_ready=1 unless stated):
- Frame 0xA5 (line: 0, 1,0,1,0,0,1,0,1, 1), each bit held 8 clk -> data_out=0xA5, data_valid high 1 cycle at edge E0+76, frame_err=0, overrun_err=0.
- rx_in low for 3 clk, then high -> returns to IDLE, busy drops, no data_valid, no error pulse.
- Frame 0x3C with stop bit 0, line then held low 40 clk -> frame_err pulse 1 cycle; FSM waits in WAIT_HIGH; no new frame until the line goes high; data_valid stays 0.
- data_ready=0; frames 0x11 then 0x22 back-to-back -> data_out=0x11, data_valid=1, overrun_err pulse at the second stop sample. Raise data_ready -> data_valid clears, data_out stays 0x11.
- Frames 0x55 and 0xAA back-to-back; data_ready pulsed on the exact cycle 0xAA loads -> data_out=0xAA, data_valid stays 1, no overrun_err.
- Assert reset during data bit 4 of 0xFF, release, send 0x81 -> all outputs 0 during reset; next byte received is 0x81 with no error.
